// File: rtl/noc_axi_master_bridge.sv
// noc_axi_master_bridge: NoC request endpoint that replays each request
// as one AXI-light master transaction and returns a response packet.
module noc_axi_master_bridge #(
    parameter int ID = 0
) (
    input  logic        clk,
    input  logic        res,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_flit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_flit,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp
);

    localparam logic [7:0] NODE   = 8'(ID);
    localparam logic [7:0] T_RD   = 8'h01;
    localparam logic [7:0] T_WR   = 8'h02;
    localparam logic [7:0] T_RRSP = 8'h81;
    localparam logic [7:0] T_WACK = 8'h82;

    typedef enum logic [3:0] {
        IDLE, ADDR, DATA, WR, B, AR, R, RSP_HDR, RSP_DATA, DROP
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [7:0]  src_q;
    logic        wr_q;
    logic [3:0]  strb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  resp_q;
    logic [1:0]  drop_q;
    logic        aw_done;
    logic        w_done;

    logic [7:0]  hdr_type;
    logic        in_fire;
    logic        aw_fire;
    logic        w_fire;
    logic        is_req;
    logic        for_us;

    assign hdr_type = in_flit[15:8];
    assign is_req   = (hdr_type == T_RD) || (hdr_type == T_WR);
    assign for_us   = in_flit[31:24] == NODE;

    assign in_ready = !res && (state inside {IDLE, ADDR, DATA, DROP});
    assign in_fire  = in_valid && in_ready;

    // AXI valids depend only on registered state, never on readies
    assign m_awvalid = (state == WR) && !aw_done;
    assign m_wvalid  = (state == WR) && !w_done;
    assign m_bready  = state == B;
    assign m_arvalid = state == AR;
    assign m_rready  = state == R;
    assign aw_fire   = m_awvalid && m_awready;
    assign w_fire    = m_wvalid && m_wready;

    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = strb_q;

    assign out_valid = state inside {RSP_HDR, RSP_DATA};

    always_comb begin
        out_flit = '0;
        if (state == RSP_HDR)
            out_flit = {src_q, NODE, wr_q ? T_WACK : T_RRSP, 6'b0, resp_q};
        else if (state == RSP_DATA)
            out_flit = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (in_fire && is_req)
                    state_d = for_us ? ADDR : DROP;
            end
            ADDR: begin
                if (in_fire) state_d = wr_q ? DATA : AR;
            end
            DATA: begin
                if (in_fire) state_d = WR;
            end
            WR: begin
                if ((aw_done || aw_fire) && (w_done || w_fire))
                    state_d = B;
            end
            B: begin
                if (m_bvalid) state_d = RSP_HDR;
            end
            AR: begin
                if (m_arready) state_d = R;
            end
            R: begin
                if (m_rvalid) state_d = RSP_HDR;
            end
            RSP_HDR: begin
                if (out_ready) state_d = wr_q ? IDLE : RSP_DATA;
            end
            RSP_DATA: begin
                if (out_ready) state_d = IDLE;
            end
            DROP: begin
                if (in_fire && drop_q == 2'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            src_q   <= '0;
            wr_q    <= 1'b0;
            strb_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            drop_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (state == IDLE && in_fire && is_req) begin
                drop_q <= (hdr_type == T_WR) ? 2'd2 : 2'd1;
                if (for_us) begin
                    src_q  <= in_flit[23:16];
                    wr_q   <= hdr_type == T_WR;
                    strb_q <= (hdr_type == T_WR) ? in_flit[3:0] : 4'h0;
                end
            end
            if (state == ADDR && in_fire)
                addr_q <= in_flit;
            if (state == DATA && in_fire) begin
                wdata_q <= in_flit;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR) begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire)  w_done  <= 1'b1;
            end
            if (state == DROP && in_fire)
                drop_q <= drop_q - 2'd1;
            if (state == B && m_bvalid)
                resp_q <= m_bresp;
            if (state == R && m_rvalid) begin
                rdata_q <= m_rdata;
                resp_q  <= m_rresp;
            end
        end
    end

endmodule

// File: tb/tb_noc_axi_master_bridge.sv
// tb_noc_axi_master_bridge: scoreboard bench with NoC driver,
// AXI-light slave model and response monitor.
module tb_noc_axi_master_bridge;

    logic        clk = 1'b0;
    logic        res;
    logic        in_valid, in_ready;
    logic [31:0] in_flit;
    logic        out_valid, out_ready;
    logic [31:0] out_flit;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic        m_wvalid, m_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;

    noc_axi_master_bridge #(.ID(5)) dut (
        .clk(clk), .res(res),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_aw[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_ws[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_out[$];

    int          aw_delay = 0;
    bit          r_block = 0;
    logic [1:0]  bresp_cfg = 2'd0;
    logic [31:0] rdata_cfg = '0;
    logic [1:0]  rresp_cfg = 2'd0;
    int          out_stall = 0;
    int          aw_cycles = 0;
    int          w_cycles = 0;
    int          ar_cycles = 0;
    int          b_early = 0;
    int          acc_cyc = 0;
    int          last_wait = 0;

    // AXI slave model: decides readies at negedge, retires the next one
    initial begin
        bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
        bit aw_done, w_done, ar_done;
        int aw_cnt;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        aw_done = 0; w_done = 0; ar_done = 0; aw_cnt = 0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        forever begin
            @(negedge clk);
            if (res) begin
                aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                aw_done = 0; w_done = 0; ar_done = 0; aw_cnt = 0;
                m_awready = 0; m_wready = 0; m_arready = 0;
                m_bvalid = 0; m_rvalid = 0;
            end else begin
                if (aw_fire) begin aw_fire = 0; aw_done = 1; m_awready = 0; end
                if (w_fire)  begin w_fire = 0; w_done = 1; m_wready = 0; end
                if (ar_fire) begin ar_fire = 0; ar_done = 1; m_arready = 0; end
                if (b_fire)  begin b_fire = 0; m_bvalid = 0; end
                if (r_fire)  begin r_fire = 0; m_rvalid = 0; end
                if (aw_done && w_done) begin
                    aw_done = 0; w_done = 0;
                    m_bvalid = 1; m_bresp = bresp_cfg;
                end
                if (ar_done && !r_block) begin
                    ar_done = 0;
                    m_rvalid = 1; m_rdata = rdata_cfg; m_rresp = rresp_cfg;
                end
                if (m_bready && (m_awvalid || m_wvalid)) b_early++;
                if (m_awvalid) begin
                    aw_cycles++;
                    aw_cnt++;
                    if (aw_cnt > aw_delay) begin
                        m_awready = 1; aw_fire = 1; aw_cnt = 0;
                        if (exp_aw.size() == 0)
                            chk("aw_extra", 32'(exp_aw.size()), 1);
                        else
                            chk("awaddr", m_awaddr, exp_aw.pop_front());
                    end
                end
                if (m_wvalid) begin
                    w_cycles++;
                    m_wready = 1; w_fire = 1;
                    if (exp_wd.size() == 0) begin
                        chk("w_extra", 32'(exp_wd.size()), 1);
                    end else begin
                        chk("wdata", m_wdata, exp_wd.pop_front());
                        chk("wstrb", 32'(m_wstrb), exp_ws.pop_front());
                    end
                end
                if (m_arvalid) begin
                    ar_cycles++;
                    m_arready = 1; ar_fire = 1;
                    if (exp_ar.size() == 0)
                        chk("ar_extra", 32'(exp_ar.size()), 1);
                    else
                        chk("araddr", m_araddr, exp_ar.pop_front());
                end
                if (m_bvalid && m_bready) b_fire = 1;
                if (m_rvalid && m_rready) r_fire = 1;
            end
        end
    end

    // Response sink with programmable backpressure
    initial begin
        bit          stalled;
        logic [31:0] prev;
        stalled = 0; prev = '0;
        out_ready = 0;
        forever begin
            @(negedge clk);
            if (res || !out_valid) begin
                out_ready = 0; stalled = 0;
            end else begin
                if (stalled) chk("out_hold", out_flit, prev);
                if (out_stall > 0) begin
                    out_stall--; out_ready = 0; stalled = 1; prev = out_flit;
                end else begin
                    out_ready = 1; stalled = 0;
                    if (exp_out.size() == 0)
                        chk("out_extra", out_flit, 32'hFFFF_FFFF);
                    else
                        chk("out_flit", out_flit, exp_out.pop_front());
                end
            end
        end
    end

    task automatic send_flit(input logic [31:0] f);
        int n = 0;
        @(negedge clk);
        in_valid = 1; in_flit = f;
        while (!in_ready && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) chk("in_tmo", 32'(n), 0);
        acc_cyc = cyc;
        last_wait = n;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return m_awvalid;
            1: return m_arvalid;
            2: return out_valid;
            3: return m_bready;
            default: return m_rready;
        endcase
    endfunction

    task automatic wait_on(input int w, output int c);
        int n = 0;
        @(negedge clk);
        while (!sig(w) && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) chk("wait_tmo", 32'(w), 32'hFFFF_FFFF);
        c = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_out.size() + exp_aw.size() + exp_wd.size()
                + exp_ar.size()) != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) chk("drain_tmo", 32'(exp_out.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, c;
        res = 1; in_valid = 0; in_flit = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_axi_ctl", 32'({m_awvalid, m_wvalid, m_arvalid,
                                m_bready, m_rready}), 0);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_awaddr", m_awaddr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_wstrb", 32'(m_wstrb), 0);
        res = 0;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 1);

        // zero-wait write
        exp_aw.push_back(32'h0000_1000);
        exp_wd.push_back(32'hDEAD_BEEF);
        exp_ws.push_back(32'hF);
        exp_out.push_back(32'h0205_8200);
        send_flit(32'h0502_020F); t0 = acc_cyc;
        send_flit(32'h0000_1000);
        send_flit(32'hDEAD_BEEF);
        wait_on(0, c); chk("wr_aw_lat", c - t0, 3);
        wait_on(2, c); chk("wr_rsp_lat", c - t0, 5);
        drain();

        // read with error response and backpressure
        rdata_cfg = 32'h1234_5678; rresp_cfg = 2'd2; out_stall = 3;
        exp_ar.push_back(32'h0000_2004);
        exp_out.push_back(32'h0305_8102);
        exp_out.push_back(32'h1234_5678);
        send_flit(32'h0503_0100); t0 = acc_cyc;
        send_flit(32'h0000_2004);
        wait_on(1, c); chk("rd_ar_lat", c - t0, 2);
        drain();

        // skewed write channels, SLVERR forwarded
        aw_delay = 4; bresp_cfg = 2'd1;
        aw_cycles = 0; w_cycles = 0; b_early = 0;
        exp_aw.push_back(32'h0000_0040);
        exp_wd.push_back(32'hA5A5_0001);
        exp_ws.push_back(32'h3);
        exp_out.push_back(32'h0905_8201);
        send_flit(32'h0509_0203); t0 = acc_cyc;
        send_flit(32'h0000_0040);
        send_flit(32'hA5A5_0001);
        wait_on(3, c); chk("skew_b_lat", c - t0, 8);
        drain();
        chk("skew_aw_cycles", aw_cycles, 5);
        chk("skew_w_cycles", w_cycles, 1);
        chk("skew_b_early", b_early, 0);
        aw_delay = 0; bresp_cfg = 2'd0;

        // misaddressed write then a normal read
        aw_cycles = 0; ar_cycles = 0;
        send_flit(32'h0703_020F); t0 = acc_cyc;
        send_flit(32'h0000_0100);
        send_flit(32'h0000_0200);
        chk("drop_span", acc_cyc - t0, 2);
        rdata_cfg = 32'hCAFE_F00D; rresp_cfg = 2'd0;
        exp_ar.push_back(32'h0000_2008);
        exp_out.push_back(32'h0305_8100);
        exp_out.push_back(32'hCAFE_F00D);
        send_flit(32'h0503_0100); t0 = acc_cyc;
        send_flit(32'h0000_2008);
        wait_on(2, c); chk("rd_rsp_lat", c - t0, 4);
        drain();
        chk("drop_aw_cycles", aw_cycles, 0);
        chk("drop_ar_cycles", ar_cycles, 1);

        // unknown type header swallowed in one cycle
        exp_aw.push_back(32'h0000_0044);
        exp_wd.push_back(32'h1122_3344);
        exp_ws.push_back(32'h3);
        exp_out.push_back(32'h0305_8200);
        send_flit(32'h0503_3300); t0 = acc_cyc;
        chk("unk_wait", last_wait, 0);
        send_flit(32'h0503_0203); t1 = acc_cyc;
        chk("unk_next", t1 - t0, 1);
        send_flit(32'h0000_0044);
        send_flit(32'h1122_3344);
        drain();

        // reset while waiting in R with rvalid arriving
        r_block = 1;
        exp_ar.push_back(32'h0000_3000);
        send_flit(32'h0503_0100);
        send_flit(32'h0000_3000);
        wait_on(4, c);
        res = 1; m_rvalid = 1; m_rdata = 32'h5555_AAAA; m_rresp = 2'd0;
        @(negedge clk);
        chk("rstR_out_valid", 32'(out_valid), 0);
        chk("rstR_axi_ctl", 32'({m_awvalid, m_wvalid, m_arvalid,
                                 m_bready, m_rready}), 0);
        chk("rstR_in_ready", 32'(in_ready), 0);
        res = 0; m_rvalid = 0; r_block = 0;
        @(negedge clk);
        chk("rstR_rel_ready", 32'(in_ready), 1);
        repeat (10) @(negedge clk);
        chk("rstR_no_rsp", 32'(exp_out.size() + exp_ar.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
